// File: rtl/msx_clock_enable_gen.sv
// MSX clock-enable generator.
// Produces a lock-qualified, stretched synchronous reset for the MSX core plus
// single-cycle CPU and PSG clock enables derived from a fractional phase
// accumulator running on the 78 MHz PLL clock. Turbo mode doubles the CPU rate;
// rate changes only take effect on a CPU-enable boundary.
module msx_clock_enable_gen #(
  parameter int ACC_W      = 24,
  parameter int INC_NORMAL = 769933,
  parameter int INC_TURBO  = 1539866,
  parameter int RST_CYCLES = 65535,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_lock,
  input  logic turbo,
  output logic sys_rst_n,
  output logic cpu_en,
  output logic psg_en,
  output logic turbo_active
);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] INC_N    = ACC_W'(INC_NORMAL);
  localparam logic [ACC_W-1:0] INC_T    = ACC_W'(INC_TURBO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] inc_sel;
  logic             carry;
  logic             psg_toggle;

  // One accumulation step, one bit wider than the accumulator so the
  // wrap-around shows up as the carry bit.
  function automatic logic [ACC_W:0] phase_step(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] inc);
    return {1'b0, a} + {1'b0, inc};
  endfunction

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Reset FSM state and stretch counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HOLD;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Reset FSM next state: count lock-qualified cycles in HOLD, drop back on lock loss.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      HOLD: begin
        if (!lock_s) begin
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  // The core reset follows the FSM state directly, so it drops asynchronously with reset_n.
  assign sys_rst_n = (state == RUN);

  // Phase accumulator sum; the increment in effect only changes on a carry.
  always_comb begin
    inc_sel           = turbo_active ? INC_T : INC_N;
    {carry, acc_next} = phase_step(acc, inc_sel);
  end

  // Accumulator, enables, PSG divider and rate selection; all parked while in HOLD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc          <= '0;
      cpu_en       <= 1'b0;
      psg_en       <= 1'b0;
      psg_toggle   <= 1'b0;
      turbo_active <= 1'b0;
    end else if (state == HOLD) begin
      acc          <= '0;
      cpu_en       <= 1'b0;
      psg_en       <= 1'b0;
      psg_toggle   <= 1'b0;
      turbo_active <= turbo;
    end else begin
      acc    <= acc_next;
      cpu_en <= carry;
      psg_en <= carry & psg_toggle;
      if (carry) begin
        psg_toggle   <= ~psg_toggle;
        turbo_active <= turbo;
      end
    end
  end

endmodule

// File: tb/tb_msx_clock_enable_gen.sv
// Directed bench for msx_clock_enable_gen with a shortened reset stretch.
module tb_msx_clock_enable_gen;

  localparam int RST_CYCLES = 16;

  logic clk;
  logic reset_n;
  logic pll_lock;
  logic turbo;
  logic sys_rst_n;
  logic cpu_en;
  logic psg_en;
  logic turbo_active;

  int checks;
  int errors;

  // running statistics, all maintained by step()
  int cpu_cnt;
  int psg_cnt;
  int b2b;
  int psg_orphan;
  int par_err;
  int idx;
  logic prev_cpu;

  msx_clock_enable_gen #(
    .ACC_W(24),
    .INC_NORMAL(769933),
    .INC_TURBO(1539866),
    .RST_CYCLES(RST_CYCLES),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pll_lock(pll_lock),
    .turbo(turbo),
    .sys_rst_n(sys_rst_n),
    .cpu_en(cpu_en),
    .psg_en(psg_en),
    .turbo_active(turbo_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and update pulse statistics.
  task automatic step();
    @(negedge clk);
    if (cpu_en && prev_cpu) b2b++;
    if (psg_en && !cpu_en) psg_orphan++;
    if (cpu_en) begin
      idx++;
      if (psg_en !== ((idx % 2) == 0)) par_err++;
    end
    if (!sys_rst_n) idx = 0;
    if (cpu_en) cpu_cnt++;
    if (psg_en) psg_cnt++;
    prev_cpu = cpu_en;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sys_rst_n !== 1'b1 && n < 200);
  endtask

  task automatic wait_cpu(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (cpu_en !== 1'b1 && n < 200);
  endtask

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    cpu_cnt    = 0;
    psg_cnt    = 0;
    b2b        = 0;
    psg_orphan = 0;
    par_err    = 0;
    idx        = 0;
    prev_cpu   = 1'b0;
    reset_n    = 1'b0;
    pll_lock   = 1'b1;
    turbo      = 1'b0;

    // reset state
    repeat (3) step();
    check_val("rst_sys_rst_n", sys_rst_n, 0);
    check_val("rst_cpu_en", cpu_en, 0);
    check_val("rst_psg_en", psg_en, 0);
    check_val("rst_turbo_active", turbo_active, 0);

    // power-up stretch: 2 sync + RST_CYCLES
    reset_n = 1'b1;
    cpu_cnt = 0;
    psg_cnt = 0;
    wait_rise(n);
    check_val("stretch_len", n, 2 + RST_CYCLES);
    check_val("en_before_rise", cpu_cnt + psg_cnt, 0);

    // first CPU enable after 22 RUN cycles, it is an odd pulse so no PSG
    wait_cpu(n);
    check_val("first_cpu", n, 22);
    check_val("first_psg", psg_en, 0);
    check_val("turbo_off", turbo_active, 0);

    // PSG alignment over 1000 CPU pulses
    n = 0;
    while (idx < 1000 && n < 30000) begin
      step();
      n++;
    end
    check_val("psg_1000_reached", idx, 1000);
    check_val("psg_parity", par_err, 0);

    // normal rate window: 20000 * 769933 / 2^24 = 917.83
    cpu_cnt = 0;
    psg_cnt = 0;
    repeat (20000) step();
    check_val("norm_cpu_cnt", cpu_cnt, (cpu_cnt == 918) ? 918 : 917);
    check_val("norm_psg_cnt", psg_cnt, (psg_cnt == 459) ? 459 : 458);

    // turbo request mid-period: takes effect only with the next carry
    wait_cpu(n);
    repeat (5) step();
    turbo = 1'b1;
    step();
    check_val("turbo_no_early", turbo_active, 0);
    n = 0;
    while (turbo_active !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check_val("turbo_on", turbo_active, 1);
    check_val("turbo_at_carry", cpu_en, 1);

    // turbo rate window: 20000 * 1539866 / 2^24 = 1835.66
    cpu_cnt = 0;
    psg_cnt = 0;
    repeat (20000) step();
    check_val("turbo_cpu_cnt", cpu_cnt, (cpu_cnt == 1836) ? 1836 : 1835);
    check_val("turbo_psg_cnt", psg_cnt, (psg_cnt == 918) ? 918 : 917);

    // dropping turbo reverts at the next carry
    wait_cpu(n);
    repeat (3) step();
    turbo = 1'b0;
    step();
    check_val("turbo_no_early_off", turbo_active, 1);
    n = 0;
    while (turbo_active !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check_val("turbo_off_again", turbo_active, 0);
    check_val("turbo_off_at_carry", cpu_en, 1);

    // lock loss for 10 cycles while running
    wait_cpu(n);
    repeat (4) step();
    pll_lock = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (sys_rst_n !== 1'b0 && n < 20);
    check_val("lock_loss_lat", n, 3);
    cpu_cnt = 0;
    psg_cnt = 0;
    repeat (7) step();
    check_val("hold_enables", cpu_cnt + psg_cnt, 0);
    pll_lock = 1'b1;
    wait_rise(n);
    check_val("relock_stretch", n, 2 + RST_CYCLES);
    wait_cpu(n);
    check_val("relock_first_cpu", n, 22);

    // asynchronous reset between edges, with enable and turbo active
    turbo = 1'b1;
    n = 0;
    while (turbo_active !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    wait_cpu(n);
    check_val("async_pre_cpu", cpu_en, 1);
    check_val("async_pre_turbo", turbo_active, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_sys_rst_n", sys_rst_n, 0);
    check_val("async_cpu_en", cpu_en, 0);
    check_val("async_psg_en", psg_en, 0);
    check_val("async_turbo_active", turbo_active, 0);
    turbo   = 1'b0;
    reset_n = 1'b1;
    wait_rise(n);
    check_val("async_restretch", n, 2 + RST_CYCLES);
    wait_cpu(n);
    check_val("async_first_cpu", n, 22);

    // global pulse-shape properties over the whole run
    check_val("no_back_to_back", b2b, 0);
    check_val("psg_without_cpu", psg_orphan, 0);
    check_val("psg_parity_all", par_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
